// File: rtl/vga_capture_monitor.sv
// Receive-side VGA timing monitor: rebuilds pixel coordinates from hsync/vsync,
// checks sync timing, captures a probe pixel and counts lit pixels per frame.
module vga_capture_monitor #(
    parameter int unsigned HPIXELS = 800,
    parameter int unsigned VLINES  = 521,
    parameter int unsigned HPULSE  = 96,
    parameter int unsigned VPULSE  = 2,
    parameter int unsigned HBP     = 144,
    parameter int unsigned HFP     = 784,
    parameter int unsigned VBP     = 31,
    parameter int unsigned VFP     = 511
) (
    input  logic        clk_pixel,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  red,
    input  logic [2:0]  green,
    input  logic [1:0]  blue,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    input  logic        clear_errors,
    output logic        locked,
    output logic        pixel_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [7:0]  probe_color,
    output logic        probe_valid,
    output logic        frame_done,
    output logic [18:0] lit_count,
    output logic        hsync_err,
    output logic        vsync_err,
    output logic        line_len_err,
    output logic        frame_len_err
);

    localparam logic [9:0] COL_LAST = 10'(HPIXELS - 1);
    localparam logic [9:0] ROW_LAST = 10'(VLINES - 1);
    localparam logic [9:0] HP       = 10'(HPULSE);
    localparam logic [9:0] VP       = 10'(VPULSE);
    localparam logic [9:0] H0       = 10'(HBP);
    localparam logic [9:0] H1       = 10'(HFP);
    localparam logic [9:0] V0       = 10'(VBP);
    localparam logic [9:0] V1       = 10'(VFP);
    localparam logic [9:0] CNT_MAX  = 10'd1023;

    typedef enum logic [1:0] {SEARCH = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        hs_p1_q, vs_p1_q, hs_p2_q, vs_p2_q;
    logic [7:0]  rgb_p1_q;
    logic [9:0]  px_p1_q, py_p1_q;
    logic [9:0]  col_q, col_d, row_q, row_d;
    logic        align_err_q, align_err_d;
    logic        hs_err_q, hs_err_d, vs_err_q, vs_err_d;
    logic        line_err_q, line_err_d, frame_err_q, frame_err_d;
    logic        valid_q, valid_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [7:0]  shadow_col_q, shadow_col_d;
    logic        shadow_vld_q, shadow_vld_d;
    logic [18:0] lit_run_q, lit_run_d;
    logic [7:0]  probe_col_q, probe_col_d;
    logic        probe_vld_q, probe_vld_d;
    logic [18:0] lit_cnt_q, lit_cnt_d;
    logic        done_q, done_d;

    logic hfall, hrise, vfall, vrise, checking, active, hit, frame_end;
    logic line_new, hs_new, vs_new, frame_new, err_new;

    // Stage 1: sample the pins; idle sync levels on reset avoid a false edge at release
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            hs_p1_q <= 1'b1;
            vs_p1_q <= 1'b1;
            hs_p2_q <= 1'b1;
            vs_p2_q <= 1'b1;
        end else begin
            hs_p1_q <= hsync;
            vs_p1_q <= vsync;
            hs_p2_q <= hs_p1_q;
            vs_p2_q <= vs_p1_q;
        end
    end

    always_ff @(posedge clk_pixel) begin
        rgb_p1_q     <= {red, green, blue};
        px_p1_q      <= probe_x;
        py_p1_q      <= probe_y;
        shadow_col_q <= shadow_col_d;
    end

    assign hfall    = hs_p2_q & ~hs_p1_q;
    assign hrise    = ~hs_p2_q & hs_p1_q;
    assign vfall    = vs_p2_q & ~vs_p1_q;
    assign vrise    = ~vs_p2_q & vs_p1_q;
    assign checking = (state_q != SEARCH);

    always_comb begin
        col_d = hfall ? 10'd0 : ((col_q == CNT_MAX) ? CNT_MAX : col_q + 10'd1);
        row_d = row_q;
        if (hfall)
            row_d = vfall ? 10'd0 : ((row_q == CNT_MAX) ? CNT_MAX : row_q + 10'd1);
        if (state_q == SEARCH && vfall)
            row_d = 10'd0;

        line_new  = checking && ((hfall && col_q != COL_LAST) ||
                                 (!hfall && col_q == CNT_MAX - 10'd1));
        hs_new    = checking && hrise && (col_d != HP);
        vs_new    = checking && ((vfall && !hfall) ||
                                 (vrise && !(hfall && row_d == VP)));
        frame_new = checking && vfall && (row_q != ROW_LAST);
        err_new   = line_new | hs_new | vs_new | frame_new;

        line_err_d  = (line_err_q  & ~clear_errors) | line_new;
        hs_err_d    = (hs_err_q    & ~clear_errors) | hs_new;
        vs_err_d    = (vs_err_q    & ~clear_errors) | vs_new;
        frame_err_d = (frame_err_q & ~clear_errors) | frame_new;

        state_d     = state_q;
        align_err_d = align_err_q;
        case (state_q)
            SEARCH: begin
                if (vfall) begin
                    state_d     = ALIGN;
                    align_err_d = 1'b0;
                end
            end
            ALIGN: begin
                if (vfall) begin
                    align_err_d = 1'b0;
                    if (!(align_err_q || err_new))
                        state_d = LOCKED;
                end else begin
                    align_err_d = align_err_q | err_new;
                end
            end
            LOCKED: begin
                if (err_new)
                    state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        active    = (col_d >= H0) && (col_d < H1) && (row_d >= V0) && (row_d < V1);
        valid_d   = active && (state_d == LOCKED);
        x_d       = active ? col_d - H0 : 10'd0;
        y_d       = active ? row_d - V0 : 10'd0;
        hit       = valid_d && (x_d == px_p1_q) && (y_d == py_p1_q);
        frame_end = vfall && (state_q == LOCKED) && (state_d == LOCKED);

        shadow_col_d = shadow_col_q;
        shadow_vld_d = shadow_vld_q;
        lit_run_d    = lit_run_q;
        probe_col_d  = probe_col_q;
        probe_vld_d  = probe_vld_q;
        lit_cnt_d    = lit_cnt_q;
        done_d       = 1'b0;

        // Partial frames (no lock, or lock just lost) are discarded; published values hold
        if (state_d != LOCKED) begin
            shadow_vld_d = 1'b0;
            lit_run_d    = 19'd0;
        end else if (frame_end) begin
            probe_col_d  = shadow_col_q;
            probe_vld_d  = shadow_vld_q;
            lit_cnt_d    = lit_run_q;
            done_d       = 1'b1;
            shadow_vld_d = 1'b0;
            lit_run_d    = 19'd0;
        end else begin
            if (hit) begin
                shadow_col_d = rgb_p1_q;
                shadow_vld_d = 1'b1;
            end
            if (valid_d && (rgb_p1_q != 8'd0))
                lit_run_d = lit_run_q + 19'd1;
        end
    end

    // Stage 2: counters, FSM, flags and published outputs
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            state_q      <= SEARCH;
            col_q        <= 10'd0;
            row_q        <= 10'd0;
            align_err_q  <= 1'b0;
            hs_err_q     <= 1'b0;
            vs_err_q     <= 1'b0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            valid_q      <= 1'b0;
            x_q          <= 10'd0;
            y_q          <= 10'd0;
            shadow_vld_q <= 1'b0;
            lit_run_q    <= 19'd0;
            probe_col_q  <= 8'd0;
            probe_vld_q  <= 1'b0;
            lit_cnt_q    <= 19'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            align_err_q  <= align_err_d;
            hs_err_q     <= hs_err_d;
            vs_err_q     <= vs_err_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
            valid_q      <= valid_d;
            x_q          <= x_d;
            y_q          <= y_d;
            shadow_vld_q <= shadow_vld_d;
            lit_run_q    <= lit_run_d;
            probe_col_q  <= probe_col_d;
            probe_vld_q  <= probe_vld_d;
            lit_cnt_q    <= lit_cnt_d;
            done_q       <= done_d;
        end
    end

    assign locked        = (state_q == LOCKED);
    assign pixel_valid   = valid_q;
    assign pix_x         = x_q;
    assign pix_y         = y_q;
    assign probe_color   = probe_col_q;
    assign probe_valid   = probe_vld_q;
    assign frame_done    = done_q;
    assign lit_count     = lit_cnt_q;
    assign hsync_err     = hs_err_q;
    assign vsync_err     = vs_err_q;
    assign line_len_err  = line_err_q;
    assign frame_len_err = frame_err_q;

endmodule

// File: tb/tb_vga_capture_monitor.sv
// Bench for vga_capture_monitor on a reduced 40x30 geometry (30x24 active) so
// many frames fit in a short run; frame results are checked through a scoreboard.
module tb_vga_capture_monitor;

    localparam int H = 40, V = 30, HPW = 5, VPW = 2, HB = 8, HF = 38, VB = 4, VF = 28;

    logic        clk_pixel = 1'b0;
    logic        rst = 1'b0;
    logic        hsync = 1'b1, vsync = 1'b1;
    logic [2:0]  red = 3'd0, green = 3'd0;
    logic [1:0]  blue = 2'd0;
    logic [9:0]  probe_x = 10'd0, probe_y = 10'd0;
    logic        clear_errors = 1'b0;
    logic        locked, pixel_valid, probe_valid, frame_done;
    logic [9:0]  pix_x, pix_y;
    logic [7:0]  probe_color;
    logic [18:0] lit_count;
    logic        hsync_err, vsync_err, line_len_err, frame_len_err;

    vga_capture_monitor #(
        .HPIXELS(H), .VLINES(V), .HPULSE(HPW), .VPULSE(VPW),
        .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF)
    ) dut (
        .clk_pixel(clk_pixel), .rst(rst), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .probe_x(probe_x), .probe_y(probe_y), .clear_errors(clear_errors),
        .locked(locked), .pixel_valid(pixel_valid), .pix_x(pix_x), .pix_y(pix_y),
        .probe_color(probe_color), .probe_valid(probe_valid), .frame_done(frame_done),
        .lit_count(lit_count), .hsync_err(hsync_err), .vsync_err(vsync_err),
        .line_len_err(line_len_err), .frame_len_err(frame_len_err)
    );

    always #5 clk_pixel = ~clk_pixel;

    int checks = 0, failures = 0, coord_err = 0;

    typedef struct {
        int         lit;
        logic [7:0] col;
        logic       pv;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    // Coordinates of the sample being driven, delayed to line up with the outputs
    logic tag_act = 1'b0, t1_act = 1'b0, t2_act = 1'b0;
    int   tag_x = 0, tag_y = 0, t1_x = 0, t1_y = 0, t2_x = 0, t2_y = 0;

    always @(posedge clk_pixel) begin
        t1_act <= tag_act; t1_x <= tag_x; t1_y <= tag_y;
        t2_act <= t1_act;  t2_x <= t1_x;  t2_y <= t1_y;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int lit, input logic [7:0] col, input logic pv);
        exp_t x;
        x.lit = lit; x.col = col; x.pv = pv;
        sb.push_back(x);
    endtask

    always @(negedge clk_pixel) begin
        if (pixel_valid && !(t2_act && pix_x == t2_x[9:0] && pix_y == t2_y[9:0]))
            coord_err++;
        if (locked && t2_act && !pixel_valid)
            coord_err++;
        if (frame_done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL frame_done_unexpected: got pulse (lit_count=%0d), required none", lit_count);
            end else begin
                e = sb.pop_front();
                chk("lit_count", 32'(lit_count), e.lit);
                chk("probe_valid", 32'(probe_valid), 32'(e.pv));
                if (e.pv) chk("probe_color", 32'(probe_color), 32'(e.col));
                chk("pixel_coord_errors", coord_err, 0);
            end
        end
    end

    function automatic logic [7:0] pcolor(input int pat, input int c, input int r);
        int ax, ay;
        bit act;
        ax  = c - HB;
        ay  = r - VB;
        act = (c >= HB && c < HF && r >= VB && r < VF);
        case (pat)
            1: return (act && ax >= 10 && ax < 16 && ay >= 10 && ay < 16) ? 8'h00 : 8'hFF;
            2: return (act && ax == 5 && ay == 7) ? 8'hE3 : 8'h00;
            3: begin
                if (!act)                   return 8'hFF;
                if (ax == 0  && ay == 0)    return 8'h01;
                if (ax == 29 && ay == 0)    return 8'h02;
                if (ax == 0  && ay == 23)   return 8'h04;
                if (ax == 29 && ay == 23)   return 8'h08;
                return 8'h00;
            end
            default: return 8'h00;
        endcase
    endfunction

    // fault: 0 none, 1 line fline is H-1 long, 2 hsync low HPW-1 on fline, 3 vsync falls at col 3
    task automatic send(input int pat, input int fault, input int fline, input int nlines,
                        input int r0, input int c0, input int nsamp, input bit lockchk);
        int r, c, n, len, hl;
        r = r0; c = c0; n = 0;
        while (r < nlines && (nsamp < 0 || n < nsamp)) begin
            len = (fault == 1 && r == fline) ? H - 1 : H;
            hl  = (fault == 2 && r == fline) ? HPW - 1 : HPW;
            @(posedge clk_pixel); #1;
            if (lockchk && r == 0 && c == 1) chk("lock_before_2_cycles", 32'(locked), 0);
            if (lockchk && r == 0 && c == 2) chk("lock_after_2_cycles", 32'(locked), 1);
            hsync = (c >= hl);
            if (fault == 3 && r == 0) vsync = (c < 3);
            else                      vsync = (r >= VPW);
            {red, green, blue} = pcolor(pat, c, r);
            tag_act = (c >= HB && c < HF && r >= VB && r < VF);
            tag_x = c - HB;
            tag_y = r - VB;
            n++; c++;
            if (c >= len) begin c = 0; r++; end
        end
    endtask

    task automatic pulse_clear(input int after);
        repeat (after) @(posedge clk_pixel);
        #1 clear_errors = 1'b1;
        @(posedge clk_pixel);
        #1 clear_errors = 1'b0;
    endtask

    function automatic logic [3:0] flags();
        return {hsync_err, vsync_err, line_len_err, frame_len_err};
    endfunction

    initial begin
        #2 rst = 1'b1;
        #2;
        chk("rst_locked", 32'(locked), 0);
        chk("rst_pixel_valid", 32'(pixel_valid), 0);
        chk("rst_pix_xy", 32'({pix_x, pix_y}), 0);
        chk("rst_probe", 32'({probe_color, probe_valid}), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_lit_count", 32'(lit_count), 0);
        chk("rst_flags", 32'(flags()), 0);
        probe_x = 10'd5; probe_y = 10'd7;
        repeat (3) @(posedge clk_pixel);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk_pixel);

        send(0, 0, 0, V, 0, 0, -1, 0);
        chk("align_not_locked", 32'(locked), 0);
        send(1, 0, 0, V, 0, 0, -1, 1);
        push_exp(684, 8'hFF, 1'b1);
        send(2, 0, 0, V, 0, 0, -1, 0);
        push_exp(1, 8'hE3, 1'b1);
        probe_x = 10'd700;
        send(1, 0, 0, V, 0, 0, -1, 0);
        push_exp(684, 8'h00, 1'b0);
        probe_x = 10'd29; probe_y = 10'd23;
        send(3, 0, 0, V, 0, 0, -1, 0);
        chk("clean_stream_flags", 32'(flags()), 0);

        // short line
        push_exp(4, 8'h08, 1'b1);
        send(0, 1, 10, V, 0, 0, -1, 0);
        chk("short_line_flags", 32'(flags()), 32'h2);
        chk("short_line_unlock", 32'(locked), 0);
        chk("hold_lit_count", 32'(lit_count), 4);
        chk("hold_probe_color", 32'(probe_color), 32'h08);
        send(0, 0, 0, V, 0, 0, -1, 0);
        chk("relock_align", 32'(locked), 0);
        fork
            send(1, 0, 0, V, 0, 0, -1, 1);
            pulse_clear(5 * H);
        join
        chk("line_err_cleared", 32'(line_len_err), 0);

        // narrow hsync
        push_exp(684, 8'hFF, 1'b1);
        send(0, 2, 5, V, 0, 0, -1, 0);
        chk("hsync_narrow_flags", 32'(flags()), 32'h8);
        chk("hsync_narrow_unlock", 32'(locked), 0);
        send(0, 0, 0, V, 0, 0, -1, 0);
        fork
            send(0, 0, 0, V, 0, 0, -1, 0);
            pulse_clear(3 * H);
        join
        chk("hsync_err_cleared", 32'(hsync_err), 0);
        chk("relock_after_hsync", 32'(locked), 1);

        // vsync falling off the hsync edge
        send(0, 3, 0, V, 0, 0, -1, 0);
        chk("vsync_misaligned_err", 32'(vsync_err), 1);
        chk("vsync_misaligned_unlock", 32'(locked), 0);
        send(0, 0, 0, V, 0, 0, -1, 0);
        fork
            send(1, 0, 0, V, 0, 0, -1, 0);
            pulse_clear(3 * H);
        join
        chk("flags_cleared", 32'(flags()), 0);
        chk("relock_after_vsync", 32'(locked), 1);

        // one line short frame, its partial results discarded
        push_exp(684, 8'hFF, 1'b1);
        send(2, 0, 0, V - 1, 0, 0, -1, 0);
        send(0, 0, 0, V, 0, 0, -1, 0);
        chk("short_frame_flags", 32'(flags()), 32'h1);
        chk("short_frame_unlock", 32'(locked), 0);
        chk("short_frame_hold_lit", 32'(lit_count), 684);

        // asynchronous reset mid-line while locked
        send(0, 0, 0, V, 0, 0, -1, 0);
        send(1, 0, 0, V, 0, 0, 10 * H + 15, 0);
        chk("pre_rst_pixel_valid", 32'(pixel_valid), 1);
        @(posedge clk_pixel);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_locked", 32'(locked), 0);
        chk("async_rst_pixel", 32'({pixel_valid, pix_x, pix_y}), 0);
        chk("async_rst_lit_count", 32'(lit_count), 0);
        chk("async_rst_flags", 32'(flags()), 0);
        fork
            send(1, 0, 0, V, 10, 15, -1, 0);
            begin
                repeat (2) @(posedge clk_pixel);
                #2 rst = 1'b0;
            end
        join
        chk("post_rst_no_spurious_flags", 32'(flags()), 0);
        chk("post_rst_unlocked", 32'(locked), 0);
        send(0, 0, 0, V, 0, 0, -1, 0);
        chk("post_rst_align_flags", 32'(flags()), 0);

        repeat (4) @(posedge clk_pixel);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        chk("final_pixel_coord_errors", coord_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
